// File: rtl/spi_master_tx_pkg.sv
// Shared types and constants for the SPI master datapath.
// Holds the FSM state encoding and the half-period timer width helper.
package spi_pkg;

    localparam int unsigned SPI_MODE = 0;
    localparam int unsigned SPI_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        TAIL,
        HOLD,
        GAP
    } state_t;

    // One extra bit keeps the width non-zero when the divider is 1.
    function automatic int unsigned timer_width(input int unsigned clk_div);
        return $unsigned($clog2(clk_div)) + 32'd1;
    endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// Byte handshake plus SPI pin bundle between a byte producer and spi_master_tx.
// The master modport is the producer side, the slave modport is the transmitter.
interface spi_master_tx_if;
    import spi_pkg::*;

    logic [SPI_BITS-1:0] txByte;
    logic                txValid;
    logic                txReady;
    logic                SPISignals_SCLK;
    logic                SPISignals_MOSI;
    logic                SPISignals_SS;
    logic                busy;
    logic                done;

    modport master (
        output txByte, txValid,
        input  txReady, SPISignals_SCLK, SPISignals_MOSI, SPISignals_SS, busy, done
    );

    modport slave (
        input  txByte, txValid,
        output txReady, SPISignals_SCLK, SPISignals_MOSI, SPISignals_SS, busy, done
    );

endinterface

// File: rtl/spi_master_tx_timer.sv
// Half-period timer: counts CLK_DIV cycles per state and flags the final one.
// tick_o is registered; restart_i starts a fresh period on the next cycle.
module spi_half_period_timer
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned W       = timer_width(CLK_DIV)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;

    // Wrap at LAST; tick is precomputed for the cycle the count lands on LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || restart_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
        tick_d = !clear_i && (cnt_d == LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: bytes in on valid/ready, MSB-first out on MOSI.
// Back-to-back bytes accepted in the last TAIL cycle share one SS-low burst.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned BITS    = SPI_BITS
) (
    input  logic           clock,
    input  logic           reset,
    spi_master_tx_if.slave io
);

    localparam int unsigned    TW       = timer_width(CLK_DIV);
    localparam int unsigned    BCW      = $clog2(BITS);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(BITS - 1);

    state_t          state_q, state_d;
    logic [BITS-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
    logic            sclk_q, sclk_d;
    logic            ss_q, ss_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick;
    logic            tx_ready_c;
    logic            accept_c;
    logic            timer_clear_c;
    logic            timer_restart_c;

    assign timer_clear_c   = (state_d == IDLE);
    assign timer_restart_c = (state_d != state_q);

    spi_half_period_timer #(
        .CLK_DIV (CLK_DIV),
        .W       (TW)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (timer_clear_c),
        .restart_i (timer_restart_c),
        .tick_o    (tick)
    );

    assign tx_ready_c = !reset && ((state_q == IDLE) || ((state_q == TAIL) && tick));
    assign accept_c   = tx_ready_c && io.txValid;

    // Next state, shift register and the registered pin levels for the next cycle.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    shreg_d   = BITS'(io.txByte);
                    bit_cnt_d = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_d = HIGH;
            end
            HIGH: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = TAIL;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        shreg_d   = {shreg_q[BITS-2:0], 1'b0};
                        state_d   = LOW;
                    end
                end
            end
            LOW: begin
                if (tick) state_d = HIGH;
            end
            TAIL: begin
                if (tick) begin
                    if (accept_c) begin
                        shreg_d   = BITS'(io.txByte);
                        bit_cnt_d = '0;
                        state_d   = SETUP;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    shreg_d = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) state_d = IDLE;
            end
            default: begin
                shreg_d   = '0;
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase

        sclk_d = (state_d == HIGH);
        ss_d   = (state_d == IDLE) || (state_d == GAP);
        busy_d = (state_d != IDLE);
        done_d = (state_q == TAIL) && tick;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            ss_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            ss_q      <= ss_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign io.txReady         = tx_ready_c;
    assign io.SPISignals_SCLK = sclk_q;
    assign io.SPISignals_MOSI = shreg_q[BITS-1];
    assign io.SPISignals_SS   = ss_q;
    assign io.busy            = busy_q;
    assign io.done            = done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx at D=4 and D=1 with a mode-0 slave model
// that shifts MOSI in on each SCLK rise while SS is low.
module tb_spi_master_tx;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    spi_master_tx_if io4 ();
    spi_master_tx_if io1 ();

    spi_master_tx #(.CLK_DIV(4)) dut4 (.clock(clock), .reset(reset), .io(io4));
    spi_master_tx #(.CLK_DIV(1)) dut1 (.clock(clock), .reset(reset), .io(io1));

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model / activity monitor, index 0 = D=4 instance, 1 = D=1 instance.
    logic     m_sclk [2];
    logic     m_mosi [2];
    logic     m_ss   [2];
    logic     m_done [2];
    assign m_sclk[0] = io4.SPISignals_SCLK;
    assign m_mosi[0] = io4.SPISignals_MOSI;
    assign m_ss[0]   = io4.SPISignals_SS;
    assign m_done[0] = io4.done;
    assign m_sclk[1] = io1.SPISignals_SCLK;
    assign m_mosi[1] = io1.SPISignals_MOSI;
    assign m_ss[1]   = io1.SPISignals_SS;
    assign m_done[1] = io1.done;

    bit       prev_sclk [2];
    bit [7:0] rx_sh [2];
    int       rx_bits [2];
    int       rises [2];
    int       hi_cyc [2];
    int       done_cnt [2];
    int       ss_rises [2];
    int       ss_run [2];
    int       ss_low_len [2];
    int       ncap [2];
    bit [7:0] cap [2][16];
    time      done_t [2][8];
    time      ss_rise_t [2];
    time      first_rise_t [2];
    time      last_rise_t [2];

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (m_ss[k] === 1'b1) begin
                rx_bits[k] <= 0;
            end else if (m_sclk[k] === 1'b1 && !prev_sclk[k]) begin
                rises[k]       <= rises[k] + 1;
                last_rise_t[k] <= $time;
                if (rx_bits[k] == 0) first_rise_t[k] <= $time;
                rx_sh[k] <= {rx_sh[k][6:0], m_mosi[k] === 1'b1};
                if (rx_bits[k] == 7) begin
                    cap[k][ncap[k][3:0]] <= {rx_sh[k][6:0], m_mosi[k] === 1'b1};
                    ncap[k]    <= ncap[k] + 1;
                    rx_bits[k] <= 0;
                end else begin
                    rx_bits[k] <= rx_bits[k] + 1;
                end
            end
            if (m_sclk[k] === 1'b1) hi_cyc[k] <= hi_cyc[k] + 1;
            if (m_ss[k] === 1'b0) begin
                ss_run[k] <= ss_run[k] + 1;
            end else if (ss_run[k] != 0) begin
                ss_low_len[k] <= ss_run[k];
                ss_run[k]     <= 0;
                ss_rises[k]   <= ss_rises[k] + 1;
                ss_rise_t[k]  <= $time;
            end
            if (m_done[k] === 1'b1) begin
                done_t[k][done_cnt[k][2:0]] <= $time;
                done_cnt[k] <= done_cnt[k] + 1;
            end
            prev_sclk[k] <= (m_sclk[k] === 1'b1);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    function automatic logic rdy(input int k);
        return (k == 0) ? io4.txReady : io1.txReady;
    endfunction

    function automatic logic busy(input int k);
        return (k == 0) ? io4.busy : io1.busy;
    endfunction

    task automatic drive(input int k, input logic [7:0] b, input logic v);
        if (k == 0) begin
            io4.txByte  = b;
            io4.txValid = v;
        end else begin
            io1.txByte  = b;
            io1.txValid = v;
        end
    endtask

    task automatic wait_ready(input int k, input string tag);
        int n = 0;
        while (rdy(k) !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check({tag, "_ready"}, 32'(rdy(k)), 32'd1);
    endtask

    task automatic wait_idle(input int k, input string tag);
        int n = 0;
        while (busy(k) !== 1'b0 && n < 2000) begin
            step();
            n++;
        end
        check({tag, "_idle"}, 32'(busy(k)), 32'd0);
    endtask

    // Returns with the handshake edge just passed; t_acc is the negedge right after it.
    task automatic send(input int k, input logic [7:0] b, input bit keep, output time t_acc);
        drive(k, b, 1'b1);
        wait_ready(k, "send");
        step();
        t_acc = $time - 1;
        if (!keep) drive(k, b, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        time ta, tb2;
        int  r0, h0, n0, d0, s0, bad;

        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        reset = 1'b1;
        repeat (3) step();

        check("rst_ss",    32'(io4.SPISignals_SS),   32'd1);
        check("rst_sclk",  32'(io4.SPISignals_SCLK), 32'd0);
        check("rst_mosi",  32'(io4.SPISignals_MOSI), 32'd0);
        check("rst_busy",  32'(io4.busy),            32'd0);
        check("rst_done",  32'(io4.done),            32'd0);
        check("rst_ready", 32'(io4.txReady),         32'd0);

        reset = 1'b0;
        step();

        // Idle with txValid low.
        d0  = done_cnt[0];
        bad = 0;
        repeat (200) begin
            step();
            if (!(io4.SPISignals_SS === 1'b1 && io4.SPISignals_SCLK === 1'b0 &&
                  io4.SPISignals_MOSI === 1'b0 && io4.txReady === 1'b1 && io4.done === 1'b0))
                bad++;
        end
        check("idle_bad_cycles", 32'(bad), 32'd0);
        check("idle_done",       32'(done_cnt[0] - d0), 32'd0);
        check("idle_ready_d1",   32'(io1.txReady), 32'd1);

        // Single byte 0x20 at D=4.
        r0 = rises[0]; h0 = hi_cyc[0]; n0 = ncap[0]; d0 = done_cnt[0]; s0 = ss_rises[0];
        send(0, 8'h20, 1'b0, ta);
        check("b20_setup_ss",   32'(io4.SPISignals_SS),   32'd0);
        check("b20_setup_sclk", 32'(io4.SPISignals_SCLK), 32'd0);
        check("b20_setup_mosi", 32'(io4.SPISignals_MOSI), 32'd0);
        check("b20_setup_busy", 32'(io4.busy),            32'd1);
        check("b20_setup_rdy",  32'(io4.txReady),         32'd0);
        wait_idle(0, "b20");
        check("b20_rises",    32'(rises[0] - r0),  32'd8);
        check("b20_hi_cyc",   32'(hi_cyc[0] - h0), 32'd32);
        check("b20_ncap",     32'(ncap[0] - n0),   32'd1);
        check("b20_byte",     32'(cap[0][n0 % 16]), 32'h20);
        check("b20_done_cnt", 32'(done_cnt[0] - d0), 32'd1);
        check("b20_done_t",   32'(done_t[0][d0 % 8] - ta), 32'd680);
        check("b20_ss_low",   32'(ss_low_len[0]), 32'd72);
        check("b20_ss_rises", 32'(ss_rises[0] - s0), 32'd1);
        check("b20_ss_rise_t", 32'(ss_rise_t[0] - ta), 32'd720);
        check("b20_ready_t",  32'(($time - 1) - ss_rise_t[0]), 32'd40);
        check("b20_ready",    32'(io4.txReady), 32'd1);

        // Back-to-back 0xA5, 0x3C with txValid held.
        r0 = rises[0]; n0 = ncap[0]; d0 = done_cnt[0]; s0 = ss_rises[0];
        send(0, 8'hA5, 1'b1, ta);
        drive(0, 8'h3C, 1'b1);
        wait_ready(0, "b2b");
        step();
        tb2 = $time - 1;
        drive(0, 8'h3C, 1'b0);
        check("b2b_accept_gap", 32'(tb2 - ta), 32'd680);
        check("b2b_ss_held",    32'(io4.SPISignals_SS), 32'd0);
        wait_idle(0, "b2b");
        check("b2b_rises",    32'(rises[0] - r0), 32'd16);
        check("b2b_ncap",     32'(ncap[0] - n0),  32'd2);
        check("b2b_byte0",    32'(cap[0][n0 % 16]), 32'hA5);
        check("b2b_byte1",    32'(cap[0][(n0 + 1) % 16]), 32'h3C);
        check("b2b_done_cnt", 32'(done_cnt[0] - d0), 32'd2);
        check("b2b_done_gap", 32'(done_t[0][(d0 + 1) % 8] - done_t[0][d0 % 8]), 32'd680);
        check("b2b_ss_rises", 32'(ss_rises[0] - s0), 32'd1);
        check("b2b_ss_low",   32'(ss_low_len[0]), 32'd140);

        // Reset in the middle of 0xFF.
        n0 = ncap[0]; d0 = done_cnt[0];
        send(0, 8'hFF, 1'b0, ta);
        repeat (28) step();
        check("rmid_pre_sclk", 32'(io4.SPISignals_SCLK), 32'd1);
        check("rmid_pre_mosi", 32'(io4.SPISignals_MOSI), 32'd1);
        reset = 1'b1;
        step();
        check("rmid_ss",   32'(io4.SPISignals_SS),   32'd1);
        check("rmid_sclk", 32'(io4.SPISignals_SCLK), 32'd0);
        check("rmid_mosi", 32'(io4.SPISignals_MOSI), 32'd0);
        check("rmid_done", 32'(io4.done),            32'd0);
        check("rmid_busy", 32'(io4.busy),            32'd0);
        reset = 1'b0;
        repeat (80) step();
        check("rmid_no_done", 32'(done_cnt[0] - d0), 32'd0);
        check("rmid_no_cap",  32'(ncap[0] - n0),     32'd0);

        r0 = rises[0]; n0 = ncap[0]; d0 = done_cnt[0];
        send(0, 8'h81, 1'b0, ta);
        wait_idle(0, "b81");
        check("b81_rises",    32'(rises[0] - r0), 32'd8);
        check("b81_byte",     32'(cap[0][n0 % 16]), 32'h81);
        check("b81_done_cnt", 32'(done_cnt[0] - d0), 32'd1);

        // D=1 instance, 0x5A.
        r0 = rises[1]; h0 = hi_cyc[1]; n0 = ncap[1]; d0 = done_cnt[1];
        send(1, 8'h5A, 1'b0, ta);
        wait_idle(1, "d1");
        check("d1_rises",    32'(rises[1] - r0),  32'd8);
        check("d1_hi_cyc",   32'(hi_cyc[1] - h0), 32'd8);
        check("d1_rise_span", 32'(last_rise_t[1] - first_rise_t[1]), 32'd140);
        check("d1_byte",     32'(cap[1][n0 % 16]), 32'h5A);
        check("d1_ss_low",   32'(ss_low_len[1]), 32'd18);
        check("d1_done_cnt", 32'(done_cnt[1] - d0), 32'd1);
        check("d1_done_t",   32'(done_t[1][d0 % 8] - ta), 32'd170);

        // txByte changes while 0xC3 is in flight.
        n0 = ncap[0];
        send(0, 8'hC3, 1'b0, ta);
        check("chg_setup_mosi", 32'(io4.SPISignals_MOSI), 32'd1);
        drive(0, 8'h3C, 1'b0);
        repeat (10) step();
        drive(0, 8'h00, 1'b0);
        wait_idle(0, "chg");
        check("chg_byte", 32'(cap[0][n0 % 16]), 32'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
